// File: rtl/seg_disp_scan.sv
// Multiplexed 7-segment scanner: handshaked shadow frame buffer committed at frame
// boundaries, blank-interval digit scanning, whole/masked flashing with a flash counter.
module seg_disp_scan #(
  parameter int DIGITS       = 5,
  parameter int SLOT_CYC     = 20000,
  parameter int BLANK_CYC    = 200,
  parameter int FLASH_FRAMES = 50,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit DIG_ACT_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*DIGITS-1:0]   frame_data,
  input  logic [1:0]            frame_mode,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [7:0]            seg_out,
  output logic [2:0]            flash_cnt,
  output logic                  flash_pulse
);

  localparam int SLOT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int POS_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FF_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYC);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(DIGITS - 1);
  localparam logic [FF_W-1:0]   FF_LAST   = FF_W'(FLASH_FRAMES - 1);
  localparam logic [DIGITS-1:0] DIG_OFF   = {DIGITS{DIG_ACT_LOW}};
  localparam logic [7:0]        SEG_OFF   = {8{SEG_ACT_LOW}};

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_FLASH = 2'd1,
    MODE_MASK  = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  // Scan position: dig_pos counts up from 0, the displayed digit index counts down.
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [POS_W-1:0]    dig_pos_q, dig_pos_d;

  logic [8*DIGITS-1:0] act_data_q, act_data_d;
  mode_e               act_mode_q, act_mode_d;
  logic [DIGITS-1:0]   act_mask_q, act_mask_d;

  logic [8*DIGITS-1:0] sh_data_q, sh_data_d;
  mode_e               sh_mode_q, sh_mode_d;
  logic [DIGITS-1:0]   sh_mask_q, sh_mask_d;
  logic                sh_full_q, sh_full_d;

  logic [FF_W-1:0]     ff_cnt_q, ff_cnt_d;
  logic                phase_on_q, phase_on_d;
  logic [2:0]          flash_cnt_q, flash_cnt_d;
  logic                flash_pulse_q, flash_pulse_d;

  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic [7:0]          seg_out_q, seg_out_d;

  logic [POS_W-1:0]    dig_idx;
  logic                slot_end;
  logic                frame_end;
  logic                accept;
  logic                commit;
  logic                flashing;
  logic [7:0]          cur_byte;
  logic                cur_mask;
  logic [DIGITS-1:0]   dig_onehot;
  logic                seg_blank;

  always_comb begin
    dig_idx   = POS_LAST - dig_pos_q;
    slot_end  = (slot_cnt_q == SLOT_LAST);
    frame_end = slot_end && (dig_pos_q == POS_LAST);
    accept    = frame_valid && !sh_full_q;
    commit    = frame_end && sh_full_q;
    flashing  = (act_mode_q == MODE_FLASH) || (act_mode_q == MODE_MASK);
  end

  always_comb begin
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + SLOT_W'(1);
    dig_pos_d  = dig_pos_q;
    if (slot_end) begin
      dig_pos_d = (dig_pos_q == POS_LAST) ? '0 : dig_pos_q + POS_W'(1);
    end
  end

  // Shadow fills on handshake; active only changes at a frame boundary so no frame tears.
  always_comb begin
    sh_data_d  = sh_data_q;
    sh_mode_d  = sh_mode_q;
    sh_mask_d  = sh_mask_q;
    sh_full_d  = sh_full_q;
    act_data_d = act_data_q;
    act_mode_d = act_mode_q;
    act_mask_d = act_mask_q;
    if (accept) begin
      sh_data_d = frame_data;
      sh_mode_d = mode_e'(frame_mode);
      sh_mask_d = blink_mask;
      sh_full_d = 1'b1;
    end
    if (commit) begin
      act_data_d = sh_data_q;
      act_mode_d = sh_mode_q;
      act_mask_d = sh_mask_q;
      sh_full_d  = 1'b0;
    end
  end

  // A commit on the same boundary as a phase toggle restarts flashing in the ON phase.
  always_comb begin
    ff_cnt_d      = ff_cnt_q;
    phase_on_d    = phase_on_q;
    flash_cnt_d   = flash_cnt_q;
    flash_pulse_d = 1'b0;
    if (!flashing) begin
      ff_cnt_d = '0;
    end
    if (commit) begin
      ff_cnt_d    = '0;
      phase_on_d  = 1'b1;
      flash_cnt_d = 3'd0;
    end else if (frame_end && flashing) begin
      if (ff_cnt_q == FF_LAST) begin
        ff_cnt_d   = '0;
        phase_on_d = !phase_on_q;
        if (!phase_on_q) begin
          flash_pulse_d = 1'b1;
          if (flash_cnt_q != 3'd7) begin
            flash_cnt_d = flash_cnt_q + 3'd1;
          end
        end
      end else begin
        ff_cnt_d = ff_cnt_q + FF_W'(1);
      end
    end
  end

  always_comb begin
    cur_byte   = 8'h00;
    cur_mask   = 1'b0;
    dig_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == POS_W'(i)) begin
        cur_byte      = act_data_q[8*i +: 8];
        cur_mask      = act_mask_q[i];
        dig_onehot[i] = 1'b1;
      end
    end
    seg_blank = (act_mode_q == MODE_BLANK) ||
                (!phase_on_q && ((act_mode_q == MODE_FLASH) ||
                                 ((act_mode_q == MODE_MASK) && cur_mask)));
    // Polarity is folded in only here, right before the output registers.
    if (slot_cnt_q < BLANK_END) begin
      dig_sel_d = DIG_OFF;
      seg_out_d = SEG_OFF;
    end else begin
      dig_sel_d = dig_onehot ^ DIG_OFF;
      seg_out_d = (seg_blank ? 8'h00 : cur_byte) ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_cnt_q    <= '0;
      dig_pos_q     <= '0;
      act_data_q    <= '0;
      act_mode_q    <= MODE_BLANK;
      act_mask_q    <= '0;
      sh_full_q     <= 1'b0;
      ff_cnt_q      <= '0;
      phase_on_q    <= 1'b1;
      flash_cnt_q   <= 3'd0;
      flash_pulse_q <= 1'b0;
      dig_sel_q     <= DIG_OFF;
      seg_out_q     <= SEG_OFF;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      dig_pos_q     <= dig_pos_d;
      act_data_q    <= act_data_d;
      act_mode_q    <= act_mode_d;
      act_mask_q    <= act_mask_d;
      sh_full_q     <= sh_full_d;
      ff_cnt_q      <= ff_cnt_d;
      phase_on_q    <= phase_on_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_pulse_q <= flash_pulse_d;
      dig_sel_q     <= dig_sel_d;
      seg_out_q     <= seg_out_d;
    end
  end

  // Shadow contents are qualified by sh_full_q, so they need no reset.
  always_ff @(posedge clk) begin
    sh_data_q <= sh_data_d;
    sh_mode_q <= sh_mode_d;
    sh_mask_q <= sh_mask_d;
  end

  assign frame_ready = !sh_full_q;
  assign dig_sel     = dig_sel_q;
  assign seg_out     = seg_out_q;
  assign flash_cnt   = flash_cnt_q;
  assign flash_pulse = flash_pulse_q;

endmodule

// File: tb/tb_seg_disp_scan.sv
// Bench for seg_disp_scan: two instances (active-high and active-low outputs) driven
// together and compared every cycle against a frame-position reference model.
module tb_seg_disp_scan;

  localparam int D     = 4;
  localparam int S     = 8;
  localparam int B     = 2;
  localparam int FF    = 2;
  localparam int FRAME = D * S;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] frame_data = '0;
  logic [1:0]  frame_mode = 2'd0;
  logic [3:0]  blink_mask = '0;
  logic        frame_valid = 1'b0;

  logic        frame_ready, frame_ready_n;
  logic [3:0]  dig_sel, dig_sel_n;
  logic [7:0]  seg_out, seg_out_n;
  logic [2:0]  flash_cnt, flash_cnt_n;
  logic        flash_pulse, flash_pulse_n;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_disp_scan #(.DIGITS(D), .SLOT_CYC(S), .BLANK_CYC(B), .FLASH_FRAMES(FF),
                  .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_mode(frame_mode),
    .blink_mask(blink_mask), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .dig_sel(dig_sel), .seg_out(seg_out), .flash_cnt(flash_cnt), .flash_pulse(flash_pulse));

  seg_disp_scan #(.DIGITS(D), .SLOT_CYC(S), .BLANK_CYC(B), .FLASH_FRAMES(FF),
                  .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_mode(frame_mode),
    .blink_mask(blink_mask), .frame_valid(frame_valid), .frame_ready(frame_ready_n),
    .dig_sel(dig_sel_n), .seg_out(seg_out_n), .flash_cnt(flash_cnt_n), .flash_pulse(flash_pulse_n));

  // Reference model: position within the frame plus active/shadow frame records.
  int          m_t = 0;
  logic [31:0] m_act_data = '0;
  int          m_act_mode = 3;
  logic [3:0]  m_act_mask = '0;
  logic        m_full = 1'b0;
  logic [31:0] m_sh_data = '0;
  int          m_sh_mode = 0;
  logic [3:0]  m_sh_mask = '0;
  int          m_ffc = 0;
  logic        m_on = 1'b1;
  int          m_cnt = 0;
  logic        m_pulse = 1'b0;
  logic [3:0]  m_dig = '0;
  logic [7:0]  m_seg = '0;
  logic        m_accepted = 1'b0;

  logic [33:0] obs_vec;
  assign obs_vec = {dig_sel, seg_out, dig_sel_n, seg_out_n, frame_ready, flash_cnt,
                    flash_pulse, frame_ready_n, flash_cnt_n, flash_pulse_n};

  function automatic logic [33:0] exp_vec();
    logic [2:0] c;
    c = 3'(m_cnt);
    return {m_dig, m_seg, ~m_dig, ~m_seg, ~m_full, c, m_pulse, ~m_full, c, m_pulse};
  endfunction

  task automatic model_edge();
    int   digit, slot;
    logic blank, acc;
    m_accepted = 1'b0;
    m_pulse    = 1'b0;
    if (!reset) begin
      m_t = 0; m_act_data = '0; m_act_mode = 3; m_act_mask = '0; m_full = 1'b0;
      m_ffc = 0; m_on = 1'b1; m_cnt = 0; m_dig = '0; m_seg = '0;
      return;
    end
    digit = D - 1 - m_t / S;
    slot  = m_t % S;
    if (slot < B) begin
      m_dig = '0; m_seg = '0;
    end else begin
      m_dig = 4'b0001 << digit;
      blank = (m_act_mode == 3) ||
              (!m_on && (m_act_mode == 1 || (m_act_mode == 2 && m_act_mask[digit])));
      m_seg = blank ? 8'h00 : m_act_data[digit*8 +: 8];
    end
    acc = frame_valid && !m_full;
    if (m_t == FRAME - 1) begin
      if (m_full) begin
        m_act_data = m_sh_data; m_act_mode = m_sh_mode; m_act_mask = m_sh_mask;
        m_full = 1'b0; m_cnt = 0; m_on = 1'b1; m_ffc = 0;
      end else if (m_act_mode == 1 || m_act_mode == 2) begin
        m_ffc++;
        if (m_ffc == FF) begin
          m_ffc = 0;
          m_on  = !m_on;
          if (m_on) begin
            m_pulse = 1'b1;
            if (m_cnt < 7) m_cnt++;
          end
        end
      end else begin
        m_ffc = 0;
      end
    end
    if (acc) begin
      m_sh_data = frame_data; m_sh_mode = int'(frame_mode); m_sh_mask = blink_mask;
      m_full = 1'b1; m_accepted = 1'b1;
    end
    m_t = (m_t + 1) % FRAME;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (m_accepted) frame_valid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] d, input logic [1:0] m, input logic [3:0] k);
    frame_data  = d;
    frame_mode  = m;
    blink_mask  = k;
    frame_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_state got=%h want=%h", obs_vec, exp_vec());
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_idle c=%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      n_cmp++;
      if (seg_out !== 8'h00 || seg_out_n !== 8'hFF || frame_ready !== 1'b1 || flash_cnt !== 3'd0) begin
        n_fail++;
        $display("FAIL idle_blank c=%0d got seg=%h segn=%h rdy=%b cnt=%0d want 00/FF/1/0",
                 c, seg_out, seg_out_n, frame_ready, flash_cnt);
      end
    end
  endtask

  task automatic test_const();
    int         c;
    logic [7:0] want;
    offer(32'h3F065B4F, 2'd0, 4'($urandom));
    tick();
    n_cmp++;
    if (frame_ready !== 1'b0 || frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL const_accept got rdy=%b want 0", frame_ready);
    end
    for (c = 0; c < 40; c++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL const_wait c=%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (frame_ready === 1'b1) break;
    end
    n_cmp++;
    if (c >= 40) begin
      n_fail++; $display("FAIL const_commit_timeout got rdy=%b want 1", frame_ready);
    end
    tick();
    for (int k = 0; k < 3 * FRAME; k++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL const_scan k=%0d got=%h want=%h", k, obs_vec, exp_vec());
      end
      case (dig_sel)
        4'b1000: want = 8'h3F;
        4'b0100: want = 8'h06;
        4'b0010: want = 8'h5B;
        4'b0001: want = 8'h4F;
        default: want = 8'h00;
      endcase
      n_cmp++;
      if (seg_out !== want || seg_out_n !== ~want) begin
        n_fail++;
        $display("FAIL const_table dig=%b got seg=%h segn=%h want %h", dig_sel, seg_out, seg_out_n, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    offer($urandom, 2'd0, 4'($urandom));
    tick();
    n_cmp++;
    if (obs_vec !== exp_vec()) begin
      n_fail++; $display("FAIL b2b_first got=%h want=%h", obs_vec, exp_vec());
    end
    offer($urandom, 2'd0, 4'($urandom));
    for (c = 0; c < 100 && frame_valid; c++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_hold c=%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
    end
    n_cmp++;
    if (frame_valid) begin
      n_fail++; $display("FAIL b2b_accept_timeout got valid still pending want accepted");
      frame_valid = 1'b0;
    end
    for (int k = 0; k < 3 * FRAME; k++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_scan k=%0d got=%h want=%h", k, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_flash_all();
    int c;
    offer($urandom | 32'h01010101, 2'd1, 4'($urandom));
    for (c = 0; c < 100; c++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL flash_wait c=%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (!frame_valid && frame_ready === 1'b1) break;
    end
    for (int k = 0; k < 31 * FRAME; k++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL flash_run k=%0d got=%h want=%h", k, obs_vec, exp_vec());
      end
    end
    n_cmp++;
    if (flash_cnt !== 3'd7) begin
      n_fail++; $display("FAIL flash_saturate got=%0d want=7", flash_cnt);
    end
    offer($urandom | 32'h01010101, 2'd1, 4'($urandom));
    for (c = 0; c < 100; c++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL flash_recommit c=%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (!frame_valid && frame_ready === 1'b1) break;
    end
    n_cmp++;
    if (flash_cnt !== 3'd0 || c >= 100) begin
      n_fail++; $display("FAIL flash_clear got cnt=%0d c=%0d want cnt=0", flash_cnt, c);
    end
  endtask

  task automatic test_flash_masked();
    logic [31:0] d;
    d = $urandom | 32'h01010101;
    offer(d, 2'd2, 4'b0011);
    for (int c = 0; c < 100; c++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL mask_wait c=%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (!frame_valid && frame_ready === 1'b1) break;
    end
    tick();
    for (int k = 0; k < 10 * FRAME; k++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL mask_run k=%0d got=%h want=%h", k, obs_vec, exp_vec());
      end
      if (dig_sel == 4'b1000 || dig_sel == 4'b0100) begin
        n_cmp++;
        if (seg_out !== (dig_sel == 4'b1000 ? d[31:24] : d[23:16])) begin
          n_fail++; $display("FAIL mask_unaffected dig=%b got=%h", dig_sel, seg_out);
        end
      end
    end
  endtask

  task automatic test_random();
    int c, len;
    for (int it = 0; it < 10; it++) begin
      offer($urandom, 2'($urandom_range(0, 3)), 4'($urandom));
      len = $urandom_range(20, 120);
      for (c = 0; c < 300; c++) begin
        tick();
        n_cmp++;
        if (obs_vec !== exp_vec()) begin
          n_fail++; $display("FAIL random it=%0d c=%0d got=%h want=%h", it, c, obs_vec, exp_vec());
        end
        if (!frame_valid && c >= len) break;
      end
      n_cmp++;
      if (frame_valid) begin
        n_fail++; $display("FAIL random_accept_timeout it=%0d got pending want accepted", it);
        frame_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    offer($urandom | 32'h01010101, 2'd0, 4'($urandom));
    for (c = 0; c < 100; c++) begin
      tick();
      if (!frame_valid && frame_ready === 1'b1) break;
    end
    for (c = 0; c < 2 * FRAME && m_t != S + 4; c++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL midrst_pre c=%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (dig_sel !== 4'b0000 || seg_out !== 8'h00 || dig_sel_n !== 4'hF || seg_out_n !== 8'hFF ||
        frame_ready !== 1'b1 || flash_cnt !== 3'd0 || flash_pulse !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got=%h want inactive outputs, ready=1", obs_vec);
    end
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL midrst_after k=%0d got=%h want=%h", k, obs_vec, exp_vec());
      end
      if (k == 2) begin
        n_cmp++;
        if (dig_sel !== 4'b1000 || seg_out !== 8'h00) begin
          n_fail++; $display("FAIL midrst_restart got dig=%b seg=%h want 1000/00", dig_sel, seg_out);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_const();
    test_back_to_back();
    test_flash_all();
    test_flash_masked();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
